btb_update_gen: RTL and testbench

Writer-side companion to the branch target buffer. It records each IF-stage BTB prediction and carries it to ID. When the branch resolves in ID, it compares the prediction against the actual outcome and emits a one-cycle registered BTB write strobe plus a fetch redirect on any misprediction. It sits between the IF/ID pipeline registers and the BTB update port, and replaces direct edge-triggered updates with a clocked, stall-aware write interface.

---
 rtl/btb_update_gen_if.sv | 53 +++++
 rtl/btb_update_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_btb_update_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_gen_if.sv
// btb_update_gen_if
//   Bundles the IF-stage capture inputs, the ID-stage resolution inputs and the
//   BTB write / fetch-redirect outputs of btb_update_gen.
//   master : pipeline side (drives STALL, IF and ID signals, receives outputs)
//   slave  : btb_update_gen side
//   Signals:
//     STALL             pipeline stall
//     Instr_PC_IN_IF    PC being fetched (0 = bubble)
//     hit_BTB_IN_IF     BTB hit for Instr_PC_IN_IF
//     Pred_PC_IN_IF     BTB predicted next PC
//     Instr_PC_IN_ID    PC of instruction in ID (0 = bubble)
//     is_Branch_IN_ID   ID instruction is a branch/jump
//     is_Taken_IN_ID    resolved direction
//     Alt_PC_IN_ID      resolved target
//     Upd_*_OUT         one-cycle BTB write strobe and payload
//     Redirect_*_OUT    fetch redirect request and PC
//     Flush_IF_OUT      squash the instruction in IF
//     *_Count_OUT       statistics counters
interface btb_update_gen_if;
    logic        STALL;
    logic [31:0] Instr_PC_IN_IF;
    logic        hit_BTB_IN_IF;
    logic [31:0] Pred_PC_IN_IF;
    logic [31:0] Instr_PC_IN_ID;
    logic        is_Branch_IN_ID;
    logic        is_Taken_IN_ID;
    logic [31:0] Alt_PC_IN_ID;
    logic        Upd_Valid_OUT;
    logic [31:0] Upd_PC_OUT;
    logic [31:0] Upd_Target_OUT;
    logic        Upd_Taken_OUT;
    logic        Redirect_OUT;
    logic [31:0] Redirect_PC_OUT;
    logic        Flush_IF_OUT;
    logic [15:0] Mispred_Count_OUT;
    logic [15:0] Branch_Count_OUT;

    modport master (
        output STALL, Instr_PC_IN_IF, hit_BTB_IN_IF, Pred_PC_IN_IF,
               Instr_PC_IN_ID, is_Branch_IN_ID, is_Taken_IN_ID, Alt_PC_IN_ID,
        input  Upd_Valid_OUT, Upd_PC_OUT, Upd_Target_OUT, Upd_Taken_OUT,
               Redirect_OUT, Redirect_PC_OUT, Flush_IF_OUT,
               Mispred_Count_OUT, Branch_Count_OUT
    );

    modport slave (
        input  STALL, Instr_PC_IN_IF, hit_BTB_IN_IF, Pred_PC_IN_IF,
               Instr_PC_IN_ID, is_Branch_IN_ID, is_Taken_IN_ID, Alt_PC_IN_ID,
        output Upd_Valid_OUT, Upd_PC_OUT, Upd_Target_OUT, Upd_Taken_OUT,
               Redirect_OUT, Redirect_PC_OUT, Flush_IF_OUT,
               Mispred_Count_OUT, Branch_Count_OUT
    );
endinterface

// File: rtl/btb_update_gen.sv
// btb_update_gen
//   Records IF-stage BTB predictions in a small FIFO, matches them against the
//   instruction resolving in ID, and on a misprediction emits a registered
//   one-cycle BTB write strobe plus a fetch redirect held until the pipeline
//   accepts it (REDIRECT), followed by one suppressed ID cycle (SQUASH).
//   Ports:
//     CLK    clock, all state on posedge
//     RESET  synchronous, active-low reset
//     bus    btb_update_gen_if.slave (IF/ID inputs, update/redirect outputs)
//   Parameters:
//     DEPTH       prediction FIFO entries (power of two, 2..8)
//     DELAY_SLOT  byte offset from branch PC to fall-through on not-taken redirect
//   Optional feature:
//     BTB_UPD_STATS_EN  enables saturating branch/mispredict counters and a
//                       per-cycle $display of both counts; otherwise both are 0.
module btb_update_gen #(
    parameter int          DEPTH      = 4,
    parameter int unsigned DELAY_SLOT = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    btb_update_gen_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_pred [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt;

    logic             lk_hit;
    logic [31:0]      lk_pred;
    logic [CNT_W-1:0] lk_npop;
    logic [PTR_W-1:0] lk_idx;

    logic             id_active;
    logic             upd_now;
    logic [31:0]      upd_tgt;
    logic             upd_tkn;
    logic             redir_now;
    logic [31:0]      redir_pc;
    logic             br_now;
    logic             fifo_clr;
    logic             push_en;
    logic             pop_en;
    logic [31:0]      fall_pc;

    logic [PTR_W-1:0] rd_pop, rd_nxt, wr_nxt;
    logic [CNT_W-1:0] cnt_pop, cnt_nxt;

    logic             vld_p1;
    logic [31:0]      upd_pc_p1;
    logic [31:0]      upd_tgt_p1;
    logic             upd_tkn_p1;
    logic [31:0]      redir_pc_p1;

    assign fall_pc = bus.Instr_PC_IN_ID + 32'(DELAY_SLOT);
    assign push_en = !bus.STALL && (bus.Instr_PC_IN_IF != 32'd0) && bus.hit_BTB_IN_IF;
    assign pop_en  = id_active && lk_hit;

    // Oldest-first search; the first match wins and everything older goes with it.
    always_comb begin
        lk_hit  = 1'b0;
        lk_pred = '0;
        lk_npop = '0;
        lk_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr + PTR_W'(i);
            if (!lk_hit && (CNT_W'(i) < cnt) && (fifo_pc[lk_idx] == bus.Instr_PC_IN_ID)) begin
                lk_hit  = 1'b1;
                lk_pred = fifo_pred[lk_idx];
                lk_npop = CNT_W'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        id_active = 1'b0;
        upd_now   = 1'b0;
        upd_tgt   = '0;
        upd_tkn   = 1'b0;
        redir_now = 1'b0;
        redir_pc  = '0;
        br_now    = 1'b0;
        fifo_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                id_active = !bus.STALL && (bus.Instr_PC_IN_ID != 32'd0);
                if (id_active) begin
                    if (bus.is_Branch_IN_ID) begin
                        br_now = 1'b1;
                        if (bus.is_Taken_IN_ID) begin
                            if (!lk_hit || (lk_pred != bus.Alt_PC_IN_ID)) begin
                                upd_now   = 1'b1;
                                upd_tgt   = bus.Alt_PC_IN_ID;
                                upd_tkn   = 1'b1;
                                redir_now = 1'b1;
                                redir_pc  = bus.Alt_PC_IN_ID;
                            end
                        end else if (lk_hit) begin
                            upd_now   = 1'b1;
                            redir_now = 1'b1;
                            redir_pc  = fall_pc;
                        end
                    end else if (lk_hit) begin
                        // A non-branch matched a prediction: the BTB entry aliases.
                        upd_now   = 1'b1;
                        redir_now = 1'b1;
                        redir_pc  = fall_pc;
                    end
                end
                if (redir_now) begin
                    state_n = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (!bus.STALL) begin
                    fifo_clr = 1'b1;
                    state_n  = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pop first, then push; a push into a still-full FIFO displaces the oldest.
    always_comb begin
        rd_pop  = pop_en ? (rd_ptr + PTR_W'(lk_npop)) : rd_ptr;
        cnt_pop = pop_en ? (cnt - lk_npop) : cnt;
        rd_nxt  = rd_pop;
        cnt_nxt = cnt_pop;
        wr_nxt  = wr_ptr;
        if (push_en) begin
            wr_nxt = wr_ptr + PTR_W'(1);
            if (cnt_pop == CNT_W'(DEPTH)) begin
                rd_nxt = rd_pop + PTR_W'(1);
            end else begin
                cnt_nxt = cnt_pop + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET || fifo_clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_en && !fifo_clr) begin
            fifo_pc[wr_ptr]   <= bus.Instr_PC_IN_IF;
            fifo_pred[wr_ptr] <= bus.Pred_PC_IN_IF;
        end
    end

    // ---- stage p1: registered update strobe / payload and redirect PC ----
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            vld_p1      <= 1'b0;
            upd_pc_p1   <= '0;
            upd_tgt_p1  <= '0;
            upd_tkn_p1  <= 1'b0;
            redir_pc_p1 <= '0;
        end else begin
            vld_p1 <= upd_now;
            if (upd_now) begin
                upd_pc_p1  <= bus.Instr_PC_IN_ID;
                upd_tgt_p1 <= upd_tgt;
                upd_tkn_p1 <= upd_tkn;
            end
            if (redir_now) begin
                redir_pc_p1 <= redir_pc;
            end
        end
    end

    assign bus.Upd_Valid_OUT   = vld_p1;
    assign bus.Upd_PC_OUT      = upd_pc_p1;
    assign bus.Upd_Target_OUT  = upd_tgt_p1;
    assign bus.Upd_Taken_OUT   = upd_tkn_p1;
    assign bus.Redirect_OUT    = (state == ST_REDIRECT);
    assign bus.Flush_IF_OUT    = (state == ST_REDIRECT);
    assign bus.Redirect_PC_OUT = redir_pc_p1;

`ifdef BTB_UPD_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    logic [15:0] br_cnt_p1;
    logic [15:0] mis_cnt_p1;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            br_cnt_p1  <= '0;
            mis_cnt_p1 <= '0;
        end else begin
            if (br_now) begin
                br_cnt_p1 <= sat_inc16(br_cnt_p1);
            end
            if (redir_now) begin
                mis_cnt_p1 <= sat_inc16(mis_cnt_p1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        $display("btb_update_gen stats: branches=%0d mispredicts=%0d", br_cnt_p1, mis_cnt_p1);
    end

    assign bus.Branch_Count_OUT  = br_cnt_p1;
    assign bus.Mispred_Count_OUT = mis_cnt_p1;
`else
    assign bus.Branch_Count_OUT  = 16'd0;
    assign bus.Mispred_Count_OUT = 16'd0;
`endif
endmodule

// File: tb/tb_btb_update_gen.sv
// tb_btb_update_gen
//   Directed scenarios followed by randomized traffic, all checked every cycle
//   against a queue-based reference model of the prediction bookkeeping.
module tb_btb_update_gen;
    localparam int          DEPTH = 4;
    localparam int unsigned DELAY = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    btb_update_gen_if bus();

    btb_update_gen #(.DEPTH(DEPTH), .DELAY_SLOT(DELAY)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    ent_t        q[$];
    bit          m_redir;
    bit          m_squash;
    logic        e_upd_vld;
    logic [31:0] e_upd_pc;
    logic [31:0] e_upd_tgt;
    logic        e_upd_tkn;
    logic [31:0] e_rpc;
    int          m_br;
    int          m_mis;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic m_mispredict(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tkn, input logic [31:0] rpc);
        e_upd_vld = 1'b1;
        e_upd_pc  = pc;
        e_upd_tgt = tgt;
        e_upd_tkn = tkn;
        e_rpc     = rpc;
        m_redir   = 1'b1;
        if (m_mis < 65535) m_mis++;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        int          hit_idx;
        logic [31:0] ppc;
        logic [31:0] idpc;
        bit          clr;
        idpc      = bus.Instr_PC_IN_ID;
        clr       = 1'b0;
        e_upd_vld = 1'b0;
        if (!RESET) begin
            q.delete();
            m_redir   = 1'b0;
            m_squash  = 1'b0;
            e_upd_pc  = '0;
            e_upd_tgt = '0;
            e_upd_tkn = 1'b0;
            e_rpc     = '0;
            m_br      = 0;
            m_mis     = 0;
            return;
        end
        if (m_redir) begin
            if (!bus.STALL) begin
                clr      = 1'b1;
                m_redir  = 1'b0;
                m_squash = 1'b1;
            end
        end else if (m_squash) begin
            m_squash = 1'b0;
        end else if (!bus.STALL && idpc != 32'd0) begin
            hit_idx = -1;
            ppc     = '0;
            foreach (q[i]) if (hit_idx < 0 && q[i].pc == idpc) hit_idx = i;
            if (hit_idx >= 0) begin
                ppc = q[hit_idx].pred;
                for (int k = 0; k <= hit_idx; k++) void'(q.pop_front());
            end
            if (bus.is_Branch_IN_ID) begin
                if (m_br < 65535) m_br++;
                if (bus.is_Taken_IN_ID) begin
                    if (hit_idx < 0 || ppc != bus.Alt_PC_IN_ID)
                        m_mispredict(idpc, bus.Alt_PC_IN_ID, 1'b1, bus.Alt_PC_IN_ID);
                end else if (hit_idx >= 0) begin
                    m_mispredict(idpc, 32'd0, 1'b0, idpc + DELAY);
                end
            end else if (hit_idx >= 0) begin
                m_mispredict(idpc, 32'd0, 1'b0, idpc + DELAY);
            end
        end
        if (!clr && !bus.STALL && bus.Instr_PC_IN_IF != 32'd0 && bus.hit_BTB_IN_IF) begin
            if (q.size() == DEPTH) void'(q.pop_front());
            q.push_back('{pc: bus.Instr_PC_IN_IF, pred: bus.Pred_PC_IN_IF});
        end
        if (clr) q.delete();
    endtask

    task automatic compare_all();
        logic [15:0] eb;
        logic [15:0] em;
`ifdef BTB_UPD_STATS_EN
        eb = 16'(m_br);
        em = 16'(m_mis);
`else
        eb = 16'd0;
        em = 16'd0;
`endif
        chk_eq("upd_valid",  32'(bus.Upd_Valid_OUT),     32'(e_upd_vld));
        chk_eq("upd_pc",     bus.Upd_PC_OUT,             e_upd_pc);
        chk_eq("upd_target", bus.Upd_Target_OUT,         e_upd_tgt);
        chk_eq("upd_taken",  32'(bus.Upd_Taken_OUT),     32'(e_upd_tkn));
        chk_eq("redirect",   32'(bus.Redirect_OUT),      32'(m_redir));
        chk_eq("flush_if",   32'(bus.Flush_IF_OUT),      32'(m_redir));
        chk_eq("redir_pc",   bus.Redirect_PC_OUT,        e_rpc);
        chk_eq("br_count",   32'(bus.Branch_Count_OUT),  32'(eb));
        chk_eq("mis_count",  32'(bus.Mispred_Count_OUT), 32'(em));
    endtask

    task automatic cyc(input bit st, input logic [31:0] ifpc, input bit hit,
                       input logic [31:0] pred, input logic [31:0] idpc,
                       input bit br, input bit tk, input logic [31:0] alt);
        bus.STALL           = st;
        bus.Instr_PC_IN_IF  = ifpc;
        bus.hit_BTB_IN_IF   = hit;
        bus.Pred_PC_IN_IF   = pred;
        bus.Instr_PC_IN_ID  = idpc;
        bus.is_Branch_IN_ID = br;
        bus.is_Taken_IN_ID  = tk;
        bus.Alt_PC_IN_ID    = alt;
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic idle(input bit st);
        cyc(st, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [15:0] exp5;
        logic [15:0] exp3;
        logic [31:0] pool_pc;
        logic [31:0] pool_id;
        int          k;

        // reset held for two cycles
        RESET = 1'b0;
        idle(1'b0);
        idle(1'b0);
        chk_eq("reset_upd_valid", 32'(bus.Upd_Valid_OUT), 32'd0);
        chk_eq("reset_redirect",  32'(bus.Redirect_OUT),  32'd0);
        RESET = 1'b1;

        // push then pop of 0x100, correctly predicted
        cyc(1'b0, 32'h100, 1'b1, 32'h200, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h100, 1'b1, 1'b1, 32'h200);
        chk_eq("pushpop_no_upd", 32'(bus.Upd_Valid_OUT), 32'd0);

        // correct prediction 0x400 -> 0x800
        cyc(1'b0, 32'h400, 1'b1, 32'h800, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h400, 1'b1, 1'b1, 32'h800);
        chk_eq("correct_no_redirect", 32'(bus.Redirect_OUT), 32'd0);

        // wrong direction, then a suppressed ID cycle
        cyc(1'b0, 32'h400, 1'b1, 32'h800, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h400, 1'b1, 1'b0, 32'h0);
        chk_eq("wrongdir_upd_pc",  bus.Upd_PC_OUT,       32'h400);
        chk_eq("wrongdir_redirpc", bus.Redirect_PC_OUT,  32'h408);
        chk_eq("wrongdir_flush",   32'(bus.Flush_IF_OUT), 32'd1);
        idle(1'b0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h400, 1'b1, 1'b1, 32'h999);
        chk_eq("squash_no_upd", 32'(bus.Upd_Valid_OUT), 32'd0);
        idle(1'b0);

        // cold miss with a 3-cycle stall while redirecting
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h500, 1'b1, 1'b1, 32'h900);
        chk_eq("cold_target", bus.Upd_Target_OUT, 32'h900);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk_eq("cold_stall_redirect", 32'(bus.Redirect_OUT), 32'd1);
        end
        idle(1'b0);
        idle(1'b0);

        // overflow: 0x10 is displaced by the fifth push
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 32'h10 + 32'(4 * i), 1'b1, 32'h110 + 32'(4 * i), 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h14, 1'b1, 1'b1, 32'h114);
        chk_eq("ovf_hit_no_upd", 32'(bus.Upd_Valid_OUT), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h10, 1'b1, 1'b1, 32'h110);
        chk_eq("ovf_dropped_upd", 32'(bus.Upd_Valid_OUT), 32'd1);
        idle(1'b0);
        idle(1'b0);

        // aliasing non-branch
        cyc(1'b0, 32'h640, 1'b1, 32'h740, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h640, 1'b0, 1'b0, 32'd0);
        chk_eq("alias_redirpc", bus.Redirect_PC_OUT, 32'h648);
        idle(1'b0);
        idle(1'b0);

        // fall-through PC wraps past 2^32
        cyc(1'b0, 32'hFFFF_FFFC, 1'b1, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0);
        chk_eq("wrap_redirpc", bus.Redirect_PC_OUT, 32'h4);
        idle(1'b0);
        idle(1'b0);

        // stats: 5 branches, 3 mispredicts after a fresh reset
        RESET = 1'b0;
        idle(1'b0);
        RESET = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h600, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h604, 1'b1, 1'b1, 32'h700);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b0, 32'h610, 1'b1, 32'h710, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h610, 1'b1, 1'b1, 32'h710);
        cyc(1'b0, 32'h620, 1'b1, 32'h720, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h620, 1'b1, 1'b0, 32'd0);
        idle(1'b0);
        idle(1'b0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 32'h630, 1'b1, 1'b1, 32'h730);
        idle(1'b0);
        idle(1'b0);
`ifdef BTB_UPD_STATS_EN
        exp5 = 16'd5;
        exp3 = 16'd3;
`else
        exp5 = 16'd0;
        exp3 = 16'd0;
`endif
        chk_eq("stats_branches",   32'(bus.Branch_Count_OUT),  32'(exp5));
        chk_eq("stats_mispredict", 32'(bus.Mispred_Count_OUT), 32'(exp3));

        // randomized traffic over a small PC pool so matches are frequent
        for (int n = 0; n < 3000; n++) begin
            RESET = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            k       = int'($urandom_range(0, 6));
            pool_pc = (k == 0) ? 32'd0 : 32'h1000 + 32'(4 * k);
            k       = int'($urandom_range(0, 6));
            pool_id = (k == 0) ? 32'd0 : 32'h1000 + 32'(4 * k);
            cyc(($urandom_range(0, 4) == 0),
                pool_pc, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'h2004,
                pool_id, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 1) == 0) ? 32'h2000 : 32'h2004);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
